wgt_grp_sched: RTL and testbench
================================

WGT_GRP_SCHED -- requirements
Module: wgt_grp_sched

Interface
REQ-001 The block SHALL have parameter IC2_LANES, default 16, meaning input channels per weight block.
REQ-002 The block SHALL have parameter OC2_LANES, default 16, meaning 2-bit output lanes per weight block.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, named clk and rst_n as elsewhere in the codebase.
REQ-004 The block SHALL have these ports (name  direction  width  meaning):
  - clk  in  1  clock.
  - rst_n  in  1  async active-low reset.
  - start  in  1  layer start pulse.
  - cfg_IC  in  16  input channel count, sampled on accepted start.
  - cfg_OC  in  16  output channel count, sampled on accepted start.
  - cfg_wgt_bits  in  5  weight width; legal values are 2, 4, 8 and 16.
  - busy  out  1  high from accepted start until the done pulse, inclusive.
  - done  out  1  one-cycle pulse when all blocks have completed.
  - cfg_err  out  1  one-cycle pulse on a rejected start.
  - wgt_load_done  in  1  weight-buffer load-complete pulse.
  - req_valid  out  1  weight block request.
  - req_ready  in  1  weight buffer accepts the request.
  - req_oc_grp  out  8  output-channel group index.
  - req_ic_grp  out  8  input-channel group index.
  - first_ic  out  1  request is the first input-channel group; qualified by req_valid.
  - last_ic  out  1  request is the last input-channel group; qualified by req_valid.
  - blk_done  in  1  pulse from the consumer: current block is fully consumed.

Function
REQ-005 The block SHALL implement the states IDLE, WAIT_LOAD, REQ, WAIT_BLK and DONE.
REQ-006 In IDLE, start SHALL sample the configuration and compute:
  - oc_per_grp = OC2_LANES/(cfg_wgt_bits/2), giving 16/8/4/2 for 2/4/8/16-bit weights.
  - n_oc = ceil(cfg_OC/oc_per_grp).
  - n_ic = ceil(cfg_IC/IC2_LANES).
REQ-007 In IDLE, start SHALL be rejected when any of these holds:
  - cfg_wgt_bits is not in {2,4,8,16};
  - cfg_IC is 0 or cfg_OC is 0;
  - n_oc > 256 or n_ic > 256.
  On rejection the block SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-008 An accepted start SHALL move the block IDLE->WAIT_LOAD, reset both group counters to 0 and assert busy from the next cycle.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 In WAIT_LOAD, wgt_load_done SHALL move the block to REQ on the next cycle; a wgt_load_done in the same cycle as start SHALL be ignored.
REQ-011 In REQ:
  - req_valid SHALL be 1.
  - req_oc_grp, req_ic_grp, first_ic and last_ic SHALL be held stable until req_ready.
  - first_ic = (ic_grp==0); last_ic = (ic_grp==n_ic-1).
REQ-012 A handshake (req_valid && req_ready) SHALL move the block REQ->WAIT_BLK, and req_valid SHALL be 0 the next cycle.
REQ-013 In WAIT_BLK, blk_done SHALL advance the counters with ic_grp as the inner loop:
  - if ic_grp < n_ic-1: ic_grp+1, go to REQ;
  - else if oc_grp < n_oc-1: ic_grp=0, oc_grp+1, go to REQ;
  - else: go to DONE.
REQ-014 blk_done SHALL be ignored outside WAIT_BLK.
REQ-015 DONE SHALL last one cycle, during which done=1 and busy=1, and SHALL then move to IDLE with busy=0.
REQ-016 Group counters SHALL be 9 bits internally so that the value 256 compares correctly; req_*_grp SHALL output the low 8 bits.
REQ-017 Request-to-request spacing SHALL be at least 2 cycles: handshake, then blk_done, then req_valid on the following cycle.
REQ-018 The total number of request handshakes per layer SHALL equal n_oc*n_ic exactly.

Reset
REQ-019 While rst_n=0, the block SHALL set:
  - state = IDLE;
  - busy, done, cfg_err, req_valid, first_ic, last_ic = 0;
  - req_oc_grp, req_ic_grp = 0;
  - the configuration registers = 0.
REQ-020 Reset asserted mid-layer SHALL abort the layer immediately with no done pulse; after release the block SHALL require a new start.

Verification
REQ-021 IC=32, OC=16, bits=2, load_done, req_ready=1, blk_done 1 cycle after each handshake -> 2 requests (0,0) first_ic=1 and (0,1) last_ic=1, then a single done pulse.
REQ-022 IC=20, OC=10, bits=8 -> n_oc=3, n_ic=2; 6 requests in order (0,0),(0,1),(1,0),(1,1),(2,0),(2,1).
REQ-023 bits=6, or IC=0, or OC=1024 with bits=16 (n_oc=512) -> cfg_err pulse, busy stays 0, no req_valid.
REQ-024 req_ready held low for 5 cycles in REQ -> req_valid and indices stable for all 5 cycles; blk_done injected during REQ and IDLE is ignored.
REQ-025 start while busy, and wgt_load_done coincident with start -> both ignored; the block waits for a later load_done.
REQ-026 rst_n pulsed low in WAIT_BLK of the 3rd block -> all outputs 0 asynchronously, no done pulse; a new start runs the full layer from (0,0).

Source files
------------

// File: rtl/wgt_grp_sched.sv
// Weight-block request scheduler: walks output-channel groups (outer) and
// input-channel groups (inner), issuing one weight-block request per pair.
module wgt_grp_sched #(
  parameter int IC2_LANES = 16,
  parameter int OC2_LANES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cfg_IC,
  input  logic [15:0] cfg_OC,
  input  logic [4:0]  cfg_wgt_bits,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  input  logic        wgt_load_done,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [7:0]  req_oc_grp,
  output logic [7:0]  req_ic_grp,
  output logic        first_ic,
  output logic        last_ic,
  input  logic        blk_done
);

  typedef enum logic [2:0] {IDLE, WAIT_LOAD, REQ, WAIT_BLK, DONE} state_t;

  state_t      state;
  logic [8:0]  n_oc_q, n_ic_q;
  logic [8:0]  oc_grp, ic_grp;
  logic [16:0] n_oc_c, n_ic_c;
  logic        bits_ok, cfg_ok;
  logic        ic_last, oc_last;

  // Divisors are always elaboration-time constants, so this folds to shifts/adds.
  function automatic logic [16:0] ceil_div(input logic [15:0] num, input int div);
    logic [31:0] n;
    n = {16'd0, num};
    return 17'((n + 32'(div) - 32'd1) / 32'(div));
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bits_ok = 1'b1;
    n_oc_c  = '0;
    case (cfg_wgt_bits)
      5'd2:    n_oc_c = ceil_div(cfg_OC, OC2_LANES);
      5'd4:    n_oc_c = ceil_div(cfg_OC, OC2_LANES / 2);
      5'd8:    n_oc_c = ceil_div(cfg_OC, OC2_LANES / 4);
      5'd16:   n_oc_c = ceil_div(cfg_OC, OC2_LANES / 8);
      default: bits_ok = 1'b0;
    endcase
    n_ic_c = ceil_div(cfg_IC, IC2_LANES);
    cfg_ok = bits_ok && (cfg_IC != 16'd0) && (cfg_OC != 16'd0) &&
             (n_oc_c <= 17'd256) && (n_ic_c <= 17'd256);
  end

  // Counters are 9 bits so a group count of exactly 256 compares correctly.
  assign ic_last    = (ic_grp == n_ic_q - 9'd1);
  assign oc_last    = (oc_grp == n_oc_q - 9'd1);
  assign req_oc_grp = oc_grp[7:0];
  assign req_ic_grp = ic_grp[7:0];

  // NOTE: state and outputs are registered with non-blocking assignments so
  // every read in this block sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      req_valid <= 1'b0;
      first_ic  <= 1'b0;
      last_ic   <= 1'b0;
      n_oc_q    <= '0;
      n_ic_q    <= '0;
      oc_grp    <= '0;
      ic_grp    <= '0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              n_oc_q <= n_oc_c[8:0];
              n_ic_q <= n_ic_c[8:0];
              oc_grp <= '0;
              ic_grp <= '0;
              busy   <= 1'b1;
              state  <= WAIT_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        WAIT_LOAD: begin
          if (wgt_load_done) begin
            req_valid <= 1'b1;
            first_ic  <= 1'b1;
            last_ic   <= (n_ic_q == 9'd1);
            state     <= REQ;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            first_ic  <= 1'b0;
            last_ic   <= 1'b0;
            state     <= WAIT_BLK;
          end
        end
        WAIT_BLK: begin
          if (blk_done) begin
            if (!ic_last) begin
              ic_grp    <= ic_grp + 9'd1;
              req_valid <= 1'b1;
              first_ic  <= 1'b0;
              last_ic   <= (ic_grp + 9'd2 == n_ic_q);
              state     <= REQ;
            end else if (!oc_last) begin
              ic_grp    <= '0;
              oc_grp    <= oc_grp + 9'd1;
              req_valid <= 1'b1;
              first_ic  <= 1'b1;
              last_ic   <= (n_ic_q == 9'd1);
              state     <= REQ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wgt_grp_sched.sv
// Self-checking bench for wgt_grp_sched: table of layer configurations plus
// hand-written stall, ignored-event and mid-layer reset sequences.
module tb_wgt_grp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_IC, cfg_OC;
  logic [4:0]  cfg_wgt_bits;
  logic        busy, done, cfg_err;
  logic        wgt_load_done;
  logic        req_valid, req_ready;
  logic [7:0]  req_oc_grp, req_ic_grp;
  logic        first_ic, last_ic;
  logic        blk_done;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] ic;
    logic [15:0] oc;
    logic [4:0]  bits;
    logic        err;
    int          noc;
    int          nic;
  } vec_t;

  vec_t vecs[10];

  wgt_grp_sched #(.IC2_LANES(16), .OC2_LANES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_IC        (cfg_IC),
    .cfg_OC        (cfg_OC),
    .cfg_wgt_bits  (cfg_wgt_bits),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .wgt_load_done (wgt_load_done),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_oc_grp    (req_oc_grp),
    .req_ic_grp    (req_ic_grp),
    .first_ic      (first_ic),
    .last_ic       (last_ic),
    .blk_done      (blk_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req_valid && req_ready) hs_count++;
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, busy, done, cfg_err, req_valid, first_ic, last_ic, req_oc_grp, req_ic_grp};
  endfunction

  // Expects the DUT in REQ at (0,0); walks every block and checks the done pulse.
  task automatic serve(input int noc, input int nic, input string tag);
    for (int o = 0; o < noc; o++) begin
      for (int i = 0; i < nic; i++) begin
        check({tag, "_req"}, {13'd0, req_valid, req_oc_grp, req_ic_grp, first_ic, last_ic},
              {13'd0, 1'b1, 8'(o), 8'(i), (i == 0), (i == nic - 1)});
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'd0, req_valid}, 32'd0);
        blk_done = 1'b1;
        step();
        blk_done = 1'b0;
      end
    end
    check({tag, "_done"}, {29'd0, done, busy, req_valid}, 32'b110);
    step();
    check({tag, "_idle"}, {29'd0, done, busy, req_valid}, 32'b000);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    hs_count     = 0;
    done_cnt     = 0;
    cfg_IC       = v.ic;
    cfg_OC       = v.oc;
    cfg_wgt_bits = v.bits;
    start        = 1'b1;
    step();
    start = 1'b0;
    if (v.err) begin
      check({tag, "_rej"}, {29'd0, cfg_err, busy, req_valid}, 32'b100);
      step();
      check({tag, "_rej_idle"}, {29'd0, cfg_err, busy, req_valid}, 32'b000);
    end else begin
      check({tag, "_acc"}, {29'd0, cfg_err, busy, req_valid}, 32'b010);
      wgt_load_done = 1'b1;
      step();
      wgt_load_done = 1'b0;
      serve(v.noc, v.nic, tag);
      check({tag, "_hs_cnt"}, hs_count, v.noc * v.nic);
      check({tag, "_done_cnt"}, done_cnt, 1);
    end
  endtask

  initial begin
    vecs[0] = '{16'd32,   16'd16,   5'd2,  1'b0, 1,   2};
    vecs[1] = '{16'd20,   16'd10,   5'd8,  1'b0, 3,   2};
    vecs[2] = '{16'd16,   16'd1,    5'd16, 1'b0, 1,   1};
    vecs[3] = '{16'd17,   16'd9,    5'd4,  1'b0, 2,   2};
    vecs[4] = '{16'd32,   16'd16,   5'd6,  1'b1, 0,   0};
    vecs[5] = '{16'd0,    16'd16,   5'd2,  1'b1, 0,   0};
    vecs[6] = '{16'd16,   16'd1024, 5'd16, 1'b1, 0,   0};
    vecs[7] = '{16'd16,   16'd0,    5'd2,  1'b1, 0,   0};
    vecs[8] = '{16'd4097, 16'd16,   5'd2,  1'b1, 0,   0};
    vecs[9] = '{16'd16,   16'd512,  5'd16, 1'b0, 256, 1};

    rst_n = 1'b0; start = 1'b0; cfg_IC = '0; cfg_OC = '0; cfg_wgt_bits = '0;
    wgt_load_done = 1'b0; req_ready = 1'b0; blk_done = 1'b0;
    step();
    step();
    check("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 10; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    run_vec('{16'd4096, 16'd2, 5'd16, 1'b0, 1, 256}, "ic256");

    // Stray blk_done in IDLE, then a stalled first request with blk_done noise.
    blk_done = 1'b1;
    step();
    step();
    blk_done = 1'b0;
    check("idle_blk_done", {30'd0, busy, req_valid}, 32'd0);
    hs_count = 0; done_cnt = 0;
    cfg_IC = 16'd32; cfg_OC = 16'd16; cfg_wgt_bits = 5'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    wgt_load_done = 1'b1;
    step();
    wgt_load_done = 1'b0;
    blk_done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("stall_c%0d", c),
            {13'd0, req_valid, req_oc_grp, req_ic_grp, first_ic, last_ic},
            {13'd0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0});
    end
    blk_done = 1'b0;
    serve(1, 2, "stall");
    check("stall_hs_cnt", hs_count, 2);

    // Load-done coincident with start, and starts while busy, are ignored.
    hs_count = 0; done_cnt = 0;
    cfg_IC = 16'd32; cfg_OC = 16'd16; cfg_wgt_bits = 5'd2;
    start = 1'b1; wgt_load_done = 1'b1;
    step();
    wgt_load_done = 1'b0;
    cfg_IC = 16'd20; cfg_OC = 16'd10; cfg_wgt_bits = 5'd6;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("busy_start_c%0d", c), {29'd0, busy, cfg_err, req_valid}, 32'b100);
    end
    start = 1'b0;
    wgt_load_done = 1'b1;
    step();
    wgt_load_done = 1'b0;
    serve(1, 2, "late_load");
    check("late_load_hs_cnt", hs_count, 2);

    // Reset during WAIT_BLK of the third block, then a clean rerun.
    done_cnt = 0;
    cfg_IC = 16'd20; cfg_OC = 16'd10; cfg_wgt_bits = 5'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    wgt_load_done = 1'b1;
    step();
    wgt_load_done = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check($sformatf("pre_rst_req%0d", b), {31'd0, req_valid}, 32'd1);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      if (b < 2) begin
        blk_done = 1'b1;
        step();
        blk_done = 1'b0;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", all_outs(), 32'd0);
    step();
    rst_n = 1'b1;
    blk_done = 1'b1; wgt_load_done = 1'b1;
    step();
    step();
    blk_done = 1'b0; wgt_load_done = 1'b0;
    check("post_rst_idle", all_outs(), 32'd0);
    check("rst_no_done", done_cnt, 0);
    run_vec(vecs[1], "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
